// File: rtl/mod_key_stepper.sv
// Two-button up/down stepper: sync, debounce, auto-repeat, 8-bit value.
// Ports: i_clk, i_nrst, i_key_up_n, i_key_down_n, i_clr -> o_value, o_step, o_key_up, o_key_down.
module mod_key_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          WRAP            = 1'b1,
  parameter logic [7:0]  INIT_VALUE      = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_key_up_n,
  input  logic       i_key_down_n,
  input  logic       i_clr,
  output logic [7:0] o_value,
  output logic       o_step,
  output logic       o_key_up,
  output logic       o_key_down
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW = $clog2(TMAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    LOCK
  } state_t;

  // bit 0 = up key, bit 1 = down key
  logic [1:0]    raw_n;
  logic [1:0]    sync1_n;
  logic [1:0]    sync2_n;
  logic [1:0]    key_sync;
  logic [1:0]    key_db;
  logic [CW-1:0] db_cnt [2];

  assign raw_n    = {i_key_down_n, i_key_up_n};
  assign key_sync = ~sync2_n;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync1_n   <= 2'b11;
      sync2_n   <= 2'b11;
      key_db    <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
      for (int k = 0; k < 2; k++) begin
        if (key_sync[k] == key_db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_LAST) begin
          key_db[k] <= key_sync[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  assign o_key_up   = key_db[0];
  assign o_key_down = key_db[1];

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic          dir_up;
  logic          dir_up_nx;
  logic          step_req;
  logic          act_key;
  logic          other_key;

  assign act_key   = dir_up ? key_db[0] : key_db[1];
  assign other_key = dir_up ? key_db[1] : key_db[0];

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    dir_up_nx = dir_up;
    step_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_db == 2'b11) begin
          state_nx = LOCK;
        end else if (key_db != 2'b00) begin
          step_req  = 1'b1;
          dir_up_nx = key_db[0];
          timer_nx  = T_DELAY;
          state_nx  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!act_key) begin
          state_nx = IDLE;
        end else if (other_key) begin
          state_nx = LOCK;
        end else if (timer == '0) begin
          step_req = 1'b1;
          timer_nx = T_PERIOD;
          state_nx = REPEAT;
        end else begin
          timer_nx = timer - T_ONE;
        end
      end
      LOCK: begin
        if (key_db == 2'b00) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [7:0] val_up;
  logic [7:0] val_dn;

  always_comb begin
    val_up = o_value + 8'd1;
    val_dn = o_value - 8'd1;
    if (!WRAP && o_value == 8'hFF) val_up = o_value;
    if (!WRAP && o_value == 8'h00) val_dn = o_value;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state   <= IDLE;
      timer   <= '0;
      dir_up  <= 1'b1;
      o_value <= INIT_VALUE;
      o_step  <= 1'b0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      dir_up <= dir_up_nx;
      // clear wins over a coincident step; FSM keeps running
      if (i_clr) begin
        o_value <= INIT_VALUE;
        o_step  <= 1'b0;
      end else if (step_req) begin
        o_value <= dir_up_nx ? val_up : val_dn;
        o_step  <= 1'b1;
      end else begin
        o_step  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_key_stepper.sv
// Bench for mod_key_stepper: a wrapping and a saturating instance
// share stimulus and are checked against a behavioural model.
module tb_mod_key_stepper;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       up_n = 1'b1;
  logic       dn_n = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] w_value, s_value;
  logic       w_step, s_step;
  logic       w_kup, w_kdn, s_kup, s_kdn;

  mod_key_stepper #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .WRAP(1'b1), .INIT_VALUE(8'h00)
  ) dut_w (
    .i_clk(clk), .i_nrst(nrst), .i_key_up_n(up_n),
    .i_key_down_n(dn_n), .i_clr(clr), .o_value(w_value),
    .o_step(w_step), .o_key_up(w_kup), .o_key_down(w_kdn)
  );

  mod_key_stepper #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .WRAP(1'b0), .INIT_VALUE(8'hFF)
  ) dut_s (
    .i_clk(clk), .i_nrst(nrst), .i_key_up_n(up_n),
    .i_key_down_n(dn_n), .i_clr(clr), .o_value(s_value),
    .o_step(s_step), .o_key_up(s_kup), .o_key_down(s_kdn)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // behavioural model
  bit [1:0]   m_d1, m_d2, m_db;
  int         m_run [2];
  int         m_mode, m_key, m_age;
  logic [7:0] m_vw, m_vs;
  bit         m_step;

  function automatic logic [7:0] nxt(input logic [7:0] v,
                                     input bit up, input bit wrap);
    if (up) return (v == 8'hFF && !wrap) ? v : v + 8'd1;
    return (v == 8'h00 && !wrap) ? v : v - 8'd1;
  endfunction

  task automatic model_reset();
    m_d1 = 2'b11; m_d2 = 2'b11; m_db = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
    m_mode = 0; m_key = 0; m_age = 0;
    m_vw = 8'h00; m_vs = 8'hFF; m_step = 0;
  endtask

  task automatic model_tick();
    bit stp;
    bit lvl;
    stp = 0;
    // 0 = idle, 1 = holding one key, 2 = locked out
    case (m_mode)
      0: begin
        if (m_db == 2'b11) m_mode = 2;
        else if (m_db != 2'b00) begin
          m_mode = 1; m_key = m_db[0] ? 0 : 1; m_age = 0; stp = 1;
        end
      end
      1: begin
        m_age++;
        if (!m_db[m_key]) m_mode = 0;
        else if (m_db[1 - m_key]) m_mode = 2;
        else if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0))
          stp = 1;
      end
      default: if (m_db == 2'b00) m_mode = 0;
    endcase
    if (clr) begin
      m_vw = 8'h00; m_vs = 8'hFF; m_step = 0;
    end else begin
      m_step = stp;
      if (stp) begin
        m_vw = nxt(m_vw, m_key == 0, 1'b1);
        m_vs = nxt(m_vs, m_key == 0, 1'b0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      lvl = !m_d2[k];
      if (lvl == m_db[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == DB) begin m_db[k] = lvl; m_run[k] = 0; end
      end
    end
    m_d2 = m_d1;
    m_d1 = {dn_n, up_n};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset();
      else model_tick();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("w_value", w_value, m_vw);
      chk("s_value", s_value, m_vs);
      chk("w_step", w_step, m_step);
      chk("s_step", s_step, m_step);
      chk("w_key_up", w_kup, m_db[0]);
      chk("w_key_down", w_kdn, m_db[1]);
      chk("s_key_up", s_kup, m_db[0]);
      chk("s_key_down", s_kdn, m_db[1]);
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t_rise, nw, ns, sat0;
    int idx[$];
    bit kseen, wrap_seen;
    logic [7:0] prev;

    repeat (3) @(negedge clk);
    chk("rst_w_value", w_value, 8'h00);
    chk("rst_s_value", s_value, 8'hFF);
    chk("rst_step", w_step, 0);
    chk("rst_key_up", w_kup, 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // single press
    up_n = 1'b0; t_rise = -1; nw = 0; ns = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (w_kup && t_rise < 0) t_rise = i;
      if (w_step) nw++;
      if (s_step) ns++;
      if (i == 5) up_n = 1'b1;
    end
    chk("t1_rise_cycle", t_rise, 6);
    chk("t1_steps", nw, 1);
    chk("t1_value", w_value, 8'h01);
    chk("t1_sat_steps", ns, 1);
    chk("t1_sat_value", s_value, 8'hFF);

    // short glitch
    up_n = 1'b0; kseen = 0; nw = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (w_kup) kseen = 1;
      if (w_step) nw++;
      if (i == 3) up_n = 1'b1;
    end
    chk("t2_key_seen", kseen, 0);
    chk("t2_steps", nw, 0);
    chk("t2_value", w_value, 8'h01);

    // hold with auto-repeat
    up_n = 1'b0; idx.delete();
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (w_step) idx.push_back(i);
      if (i == 46) up_n = 1'b1;
    end
    chk("t3_nsteps", idx.size(), 13);
    chk("t3_step0", idx.size() > 0 ? idx[0] : -1, 7);
    chk("t3_step1", idx.size() > 1 ? idx[1] : -1, 17);
    chk("t3_step2", idx.size() > 2 ? idx[2] : -1, 20);
    chk("t3_step3", idx.size() > 3 ? idx[3] : -1, 23);
    chk("t3_last", idx.size() > 0 ? idx[idx.size() - 1] : -1, 50);
    chk("t3_value", w_value, 8'd14);

    // long down hold: wrap below 0 and saturate at 0
    do_reset();
    dn_n = 1'b0; prev = w_value; wrap_seen = 0; sat0 = 0;
    for (int i = 1; i <= 820; i++) begin
      @(negedge clk);
      if (w_step && prev == 8'h00 && w_value == 8'hFF) wrap_seen = 1;
      prev = w_value;
      if (s_step && s_value == 8'h00) sat0++;
      if (i == 800) dn_n = 1'b1;
    end
    chk("t4_wrap_seen", wrap_seen, 1);
    chk("t4_wrap_value", w_value, 8'd247);
    chk("t4_sat_value", s_value, 8'h00);
    chk("t4_sat_pulses", sat0, 11);

    // both keys lock out stepping
    do_reset();
    up_n = 1'b0; nw = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (w_step) nw++;
      if (i == 8) dn_n = 1'b0;
      if (i == 30) up_n = 1'b1;
    end
    chk("t5_lock_steps", nw, 1);
    chk("t5_lock_value", w_value, 8'h01);
    dn_n = 1'b1; nw = 0;
    repeat (20) begin
      @(negedge clk);
      if (w_step) nw++;
    end
    chk("t5_release_steps", nw, 0);
    dn_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (w_step) nw++;
      if (i == 5) dn_n = 1'b1;
    end
    chk("t5_down_steps", nw, 1);
    chk("t5_down_value", w_value, 8'h00);

    // clear on a repeat step, then reset mid-hold
    do_reset();
    up_n = 1'b0;
    repeat (31) @(negedge clk);
    chk("t6_pre_value", w_value, 8'd6);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_clr_value", w_value, 8'h00);
    chk("t6_clr_step", w_step, 0);
    chk("t6_clr_sat", s_value, 8'hFF);
    repeat (3) @(negedge clk);
    chk("t6_after_clr_value", w_value, 8'h01);
    chk("t6_after_clr_step", w_step, 1);
    repeat (4) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6_arst_w_value", w_value, 8'h00);
    chk("t6_arst_s_value", s_value, 8'hFF);
    chk("t6_arst_key_up", w_kup, 0);
    chk("t6_arst_key_down", w_kdn, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_rehold_pre", w_value, 8'h00);
    @(negedge clk);
    chk("t6_rehold_value", w_value, 8'h01);
    chk("t6_rehold_step", w_step, 1);
    up_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_key_stepper.md
Name: mod_key_stepper

Overview:
- Input-side companion to the byte display path.
- Reads two active-low pushbuttons (up/down), synchronises and debounces them, and steps an 8-bit value.
- Each press gives one step; holding a key auto-repeats.
- o_value feeds the display value input in place of the free-running counter; everything runs on the system clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised key must differ from its debounced state before that state changes (>=2).
REPEAT_DELAY, 25000000, cycles from the initial step to the first auto-repeat step (>=2).
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps (>=2).
WRAP, 1, 1 = value wraps 255<->0; 0 = value saturates at 0 and 255.
INIT_VALUE, 8'h00, value loaded by reset and by i_clr.

Ports:
i_clk  input  1  system clock
i_nrst  input  1  asynchronous active-low reset
i_key_up_n  input  1  raw up button, active low, asynchronous to i_clk
i_key_down_n  input  1  raw down button, active low, asynchronous to i_clk
i_clr  input  1  synchronous clear of o_value to INIT_VALUE
o_value  output  8  current stepped value
o_step  output  1  one-cycle pulse in the cycle o_value is updated by a step
o_key_up  output  1  debounced up key, active high
o_key_down  output  1  debounced down key, active high

Behaviour:
- One clock; reset is asynchronous, active-low.
- Reset values: o_value=INIT_VALUE, o_step=0, o_key_up=0, o_key_down=0, FSM=IDLE. Synchroniser flops and debounce counters reset to the released state (1) and 0.
- Sync: each raw key passes through 2 flops, then is inverted to active high.
- Debounce, per key:
  - counter clears whenever the synchronised level equals the debounced level;
  - otherwise it increments;
  - on the DEBOUNCE_CYCLES-th consecutive differing sample, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes o_key_*.
- FSM states: IDLE, DELAY, REPEAT, LOCK. A timer is loaded on each step.
  - IDLE, exactly one debounced key high: step in that key's direction, load timer=REPEAT_DELAY-1, go to DELAY.
  - IDLE, both keys high: no step, go to LOCK.
  - DELAY/REPEAT, active key released: go to IDLE, no step.
  - DELAY/REPEAT, other key becomes high: go to LOCK, no step.
  - DELAY/REPEAT, otherwise timer decrements. When timer==0: step, load timer=REPEAT_PERIOD-1, go to (or stay in) REPEAT.
  - LOCK: stay until both keys are low, then go to IDLE.
- Step timing: one step in the cycle after the debounced level rises. Auto-repeat steps follow exactly REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles.
- Arithmetic, 8-bit unsigned:
  - WRAP=1: 255+1=0 and 0-1=255.
  - WRAP=0: 255 holds on up, 0 holds on down. o_step still pulses even though the value is unchanged.
- o_value and o_step are registered. o_step is high for exactly the cycle in which the new o_value first appears.
- i_clr has priority over a step in the same cycle: o_value=INIT_VALUE, o_step=0. The FSM and timer are unaffected.
- Reset mid-hold: everything returns to reset values. If a key is still held after reset, it is debounced again from scratch and produces a fresh initial step.

Test Plan:
1. Params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, WRAP=1. Hold up low for 5 cycles, then release -> o_key_up rises 2+4 cycles after the input edge; exactly one o_step; o_value 0->1.
2. Glitch: drive up low for 3 cycles, then high -> o_key_up stays 0, o_step never pulses, o_value stays 0.
3. Hold up for 40 cycles after debounce -> steps at t0, t0+10, t0+13, t0+16 ... and o_value increments on each. Releasing stops steps; no step after release.
4. Wrap/saturate: from 255 press up -> WRAP=1 gives 0. Rerun with WRAP=0 -> value stays 255, o_step pulses once; from 0 press down -> stays 0.
5. Both keys: hold up, then press down during DELAY -> no further steps. Release up only -> still no steps. Release both, then press down -> one step, value decrements.
6. i_clr asserted in the same cycle as a repeat step at value 7 -> o_value=INIT_VALUE, o_step=0. Assert i_nrst low mid-hold -> all outputs are at reset values immediately, asynchronously.
